// File: rtl/uart_program_loader_if.sv
// Memory write bus between uart_program_loader and the instruction memory mux.
// master: the loader drives the write strobe, word address and data.
// slave:  the memory side consumes them.
interface uart_program_loader_if #(
  parameter int ADDR_W = 15
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed 8N1 byte stream on uart_rx and writes
// big-endian 32-bit words into instruction memory starting at word address 0.
// The CPU is held while a load is in progress or after a failed load.
// Frame: A5, count_hi, count_lo, 4*N data bytes [, XOR checksum byte].
// Optional feature macro: LOADER_CSUM_EN (adds the trailing XOR checksum byte).
module uart_program_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 15
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   uart_rx,
  uart_program_loader_if.master  mem,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_error,
  output logic [15:0]            words_loaded
);

  localparam int DIV_RAW = CLK_HZ / BAUD;
  localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int CNT_W   = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] HALF_DIV = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
  // Largest legal word count: the whole address space.
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } fr_state_t;

  // ---------------------------------------------------------------- RX side
  logic [1:0]       sync_q, sync_d;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer input shift; both stages idle high.
  always_comb begin
    sync_d = {sync_q[0], uart_rx};
  end

  // RX bit-timing FSM: mid-bit sampling, LSB first, stop bit check.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_DIV;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;  // start bit did not survive: glitch
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX registers; the synchronizer resets to the idle-high line level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q       <= 2'b11;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ------------------------------------------------------------ Framer side
  fr_state_t         fr_state_q, fr_state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       n_words_q, n_words_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic [15:0]       n_new_s;
  logic              goto_done_s;
  logic              goto_err_s;

  assign n_new_s = {cnt_hi_q, rx_shift_q};

  // Framer next state: header parse, word assembly, write/increment sequencing.
  always_comb begin
    fr_state_d  = fr_state_q;
    cnt_hi_d    = cnt_hi_q;
    n_words_d   = n_words_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    addr_d      = addr_q;
    words_d     = words_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    goto_done_s = 1'b0;
    goto_err_s  = 1'b0;
    case (fr_state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (byte_valid_q && (rx_shift_q == 8'hA5)) begin
          fr_state_d = S_CNT_HI;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = 16'd0;
          addr_d     = '0;
          byte_idx_d = 2'd0;
`ifdef LOADER_CSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          fr_state_d = fr_state_q;
        end
      end
      S_CNT_HI: begin
        if (frame_err_q) begin
          goto_err_s = 1'b1;
        end else if (byte_valid_q) begin
          cnt_hi_d   = rx_shift_q;
          fr_state_d = S_CNT_LO;
        end else begin
          fr_state_d = S_CNT_HI;
        end
      end
      S_CNT_LO: begin
        if (frame_err_q) begin
          goto_err_s = 1'b1;
        end else if (byte_valid_q) begin
          n_words_d = n_new_s;
          if ({16'd0, n_new_s} > MAX_WORDS) begin
            goto_err_s = 1'b1;
          end else if (n_new_s == 16'd0) begin
`ifdef LOADER_CSUM_EN
            fr_state_d = S_CSUM;
`else
            goto_done_s = 1'b1;
`endif
          end else begin
            fr_state_d = S_DATA;
            byte_idx_d = 2'd0;
          end
        end else begin
          fr_state_d = S_CNT_LO;
        end
      end
      S_DATA: begin
        if (we_q) begin
          // Cycle after the write strobe: advance address and count.
          addr_d  = addr_q + ADDR_ONE;
          words_d = words_q + 16'd1;
          if ((words_q + 16'd1) == n_words_q) begin
`ifdef LOADER_CSUM_EN
            fr_state_d = S_CSUM;
`else
            goto_done_s = 1'b1;
`endif
          end else begin
            fr_state_d = S_DATA;
          end
        end else if (frame_err_q) begin
          goto_err_s = 1'b1;
        end else if (byte_valid_q) begin
          asm_d      = {asm_q[23:0], rx_shift_q};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CSUM_EN
          csum_d     = csum_q ^ rx_shift_q;
`endif
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {asm_q[23:0], rx_shift_q};
          end else begin
            we_d = 1'b0;
          end
        end else begin
          fr_state_d = S_DATA;
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (frame_err_q) begin
          goto_err_s = 1'b1;
        end else if (byte_valid_q) begin
          if (rx_shift_q == csum_q) begin
            goto_done_s = 1'b1;
          end else begin
            goto_err_s = 1'b1;
          end
        end else begin
          fr_state_d = S_CSUM;
        end
      end
`endif
      default: begin
        fr_state_d = S_IDLE;
      end
    endcase
    if (goto_err_s) begin
      fr_state_d = S_ERR;
      err_d      = 1'b1;
      hold_d     = 1'b1;
    end else if (goto_done_s) begin
      fr_state_d = S_DONE;
      done_d     = 1'b1;
      hold_d     = 1'b0;
    end else begin
      err_d = err_d;
    end
  end

  // Framer registers and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fr_state_q <= S_IDLE;
      cnt_hi_q   <= 8'h00;
      n_words_q  <= 16'd0;
      byte_idx_q <= 2'd0;
      asm_q      <= 32'h0000_0000;
      addr_q     <= '0;
      words_q    <= 16'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      fr_state_q <= fr_state_d;
      cnt_hi_q   <= cnt_hi_d;
      n_words_q  <= n_words_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_error    = err_q;
  assign words_loaded  = words_q;

endmodule
